// File: rtl/pac_man_pkg.sv
// Shared types for the pac-man input path: headings, control states
// and the one-hot heading encoding consumed by pac_man_behavior.
package pac_man_pkg;

   localparam int TICK_DIV_DEFAULT = 6_250_000;
   localparam int DEBOUNCE_DEFAULT = 500_000;
   localparam int SYNC_DEFAULT     = 2;

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE
   } ctrl_state_t;

   // {up,down,left,right}; NONE maps to 0000 so the consumer holds still
   function automatic logic [3:0] dir_to_onehot(input dir_t d);
      logic [3:0] oh;
      oh = 4'b0000;
      case (d)
         DIR_UP:    oh = 4'b1000;
         DIR_DOWN:  oh = 4'b0100;
         DIR_LEFT:  oh = 4'b0010;
         DIR_RIGHT: oh = 4'b0001;
         default:   oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw key: synchroniser, consecutive-sample debounce and a
// registered one-cycle pulse on each accepted press.
module key_debounce #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   stable_d;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // shift the raw level through the synchroniser chain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
   end

   // accept a new level after DEBOUNCE_CYC consecutive differing samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         stable <= 1'b0;
      end else if (sync_s == stable) begin
         cnt_q  <= '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q  <= '0;
         stable <= sync_s;
      end else begin
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   // registered rising-edge pulse of the debounced level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_d <= 1'b0;
         press    <= 1'b0;
      end else begin
         stable_d <= stable;
         press    <= stable & ~stable_d;
      end
   end

endmodule

// File: rtl/pac_man_input_ctrl.sv
// Key front end for pac_man_behavior: sticky pending heading, game
// rate tick and tick-aligned commit of the one-hot direction.
module pac_man_input_ctrl
   import pac_man_pkg::*;
#(
   parameter int TICK_DIV     = TICK_DIV_DEFAULT,
   parameter int DEBOUNCE_CYC = DEBOUNCE_DEFAULT,
   parameter int SYNC_STAGES  = SYNC_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic key_up,
   input  logic key_down,
   input  logic key_left,
   input  logic key_right,
   input  logic enable,
   output logic start,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic move_tick
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [3:0]  key_raw;
   logic [3:0]  key_press;
   logic        any_press;
   ctrl_state_t state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic        start_q, start_d;
   logic        tick;
   dir_t        pend_q, pend_d;
   logic [3:0]  dir_q;

   assign key_raw   = {key_up, key_down, key_left, key_right};
   assign any_press = |key_press;

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_debounce #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_key (
         .clk    (clk),
         .reset  (reset),
         .raw    (key_raw[i]),
         .stable (),
         .press  (key_press[i])
      );
   end

   // newest press wins; simultaneous presses resolve UP>DOWN>LEFT>RIGHT
   always_comb begin
      pend_d = pend_q;
      if      (key_press[3]) pend_d = DIR_UP;
      else if (key_press[2]) pend_d = DIR_DOWN;
      else if (key_press[1]) pend_d = DIR_LEFT;
      else if (key_press[0]) pend_d = DIR_RIGHT;
   end

   // run/pause control and the move period counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = start_q;
      tick    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (any_press && enable) begin
               state_d = S_RUN;
               start_d = 1'b1;
            end
         end
         S_RUN: begin
            tick  = (cnt_q == TICK_LAST);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (!enable) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (enable) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // control state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
      end
   end

   // pending heading and its commit at the end of each tick cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= DIR_NONE;
         dir_q  <= 4'b0000;
      end else begin
         pend_q <= pend_d;
         if (tick) dir_q <= dir_to_onehot(pend_q);
      end
   end

   assign start     = start_q;
   assign move_tick = tick;
   assign {up, down, left, right} = dir_q;

endmodule

// File: tb/tb_pac_man_input_ctrl.sv
// Bench for pac_man_input_ctrl: directed vectors, corner sequences and
// random key/enable traffic against a cycle-level behavioural model.
module tb_pac_man_input_ctrl;

   localparam int TD = 8;
   localparam int DB = 4;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic enable = 1'b0;
   logic start, up, down, left, right, move_tick;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pac_man_input_ctrl #(
      .TICK_DIV     (TD),
      .DEBOUNCE_CYC (DB),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_left  (key_left),
      .key_right (key_right),
      .enable    (enable),
      .start     (start),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .move_tick (move_tick)
   );

   // model, key vectors ordered {up,down,left,right}
   bit [31:0] hist [4];
   bit        mst1 [4];
   bit        mst2 [4];
   bit [3:0]  mpress;
   bit        started;
   int        mode;
   int        runcnt;
   bit [3:0]  mpend;
   bit [3:0]  mdir;
   bit        mtick;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         hist[i] = '0;
         mst1[i] = 1'b0;
         mst2[i] = 1'b0;
      end
      mpress  = '0;
      started = 1'b0;
      mode    = 0;
      runcnt  = 0;
      mpend   = '0;
      mdir    = '0;
      mtick   = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] k, input logic en);
      bit [3:0] p;
      bit       nst;
      bit       diff;
      p = mpress;
      if (mtick) mdir = mpend;
      for (int i = 3; i >= 0; i--) begin
         if (p[i]) begin
            mpend = 4'(1 << i);
            break;
         end
      end
      case (mode)
         0: if ((|p) && en) begin
               mode = 1;
               started = 1'b1;
               runcnt = 0;
            end
         1: begin
               runcnt++;
               if (!en) mode = 2;
            end
         default: if (en) mode = 1;
      endcase
      mtick = (mode == 1) && (runcnt % TD == TD - 1);
      for (int i = 0; i < 4; i++) begin
         hist[i] = {hist[i][30:0], k[i]};
         diff = 1'b1;
         for (int j = 0; j < DB; j++)
            if (hist[i][SS+j] == mst1[i]) diff = 1'b0;
         nst = diff ? ~mst1[i] : mst1[i];
         mpress[i] = mst1[i] & ~mst2[i];
         mst2[i] = mst1[i];
         mst1[i] = nst;
      end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] k, input logic en);
      {key_up, key_down, key_left, key_right} = k;
      enable = en;
      @(posedge clk);
      model_edge(k, en);
      #1;
      n_cmp++;
      if ({start, move_tick, up, down, left, right} !== {started, mtick, mdir}) begin
         n_bad++;
         $display("FAIL model t=%0t: got %b expected %b", $time,
                  {start, move_tick, up, down, left, right},
                  {started, mtick, mdir});
      end
   endtask

   task automatic do_reset(input string nm);
      #2 reset = 1'b1;
      #1;
      chk(nm, {start, move_tick, up, down, left, right}, 0);
      @(posedge clk);
      model_reset();
      #1 reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0] keys;
      logic       en;
      logic       exp_start;
      logic       exp_tick;
      logic [3:0] exp_dir;
   } vec_t;

   vec_t tbl [17];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] ks;
      logic       en;
      int         got;
      bit         seen;

      for (int k = 0; k < 17; k++) begin
         tbl[k].keys      = 4'b0001;
         tbl[k].en        = 1'b1;
         tbl[k].exp_start = (k + 1 >= 8);
         tbl[k].exp_tick  = (k + 1 == 15);
         tbl[k].exp_dir   = (k + 1 >= 16) ? 4'b0001 : 4'b0000;
      end

      model_reset();
      #1;
      chk("reset_state", {start, move_tick, up, down, left, right}, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // right held from cycle 0: press 7, start 8, tick 15, right 16
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].keys, tbl[i].en);
         chk($sformatf("tbl_right_%0d", i),
             {start, move_tick, up, down, left, right},
             {tbl[i].exp_start, tbl[i].exp_tick, tbl[i].exp_dir});
      end

      // short glitch is ignored
      do_reset("reset_glitch");
      for (int i = 0; i < 3; i++) step(4'b1000, 1'b1);
      for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
      chk("glitch_outputs", {start, up, down, left, right}, 0);

      // simultaneous down+left resolves to down
      do_reset("reset_simul");
      for (int i = 0; i < 17; i++) step(4'b0110, 1'b1);
      chk("simul_dir", {up, down, left, right}, 4'b0100);

      // reset mid run with left held
      do_reset("reset_run_prep");
      for (int i = 0; i < 12; i++) step(4'b0010, 1'b1);
      chk("run_started", start, 1);
      do_reset("reset_mid_run");
      seen = 1'b0;
      for (int i = 0; i < 13; i++) begin
         step(i < 3 ? 4'b0010 : 4'b0000, 1'b1);
         if (start || move_tick) seen = 1'b1;
      end
      chk("post_reset_idle", seen, 0);

      // pause with heading up, left pressed while paused
      do_reset("reset_pause");
      for (int i = 0; i < 17; i++) step(4'b1000, 1'b1);
      for (int i = 0; i < 2; i++) step(4'b0000, 1'b1);
      chk("pause_pre_up", {up, down, left, right}, 4'b1000);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(i < 8 ? 4'b0010 : 4'b0000, 1'b0);
         if (move_tick) seen = 1'b1;
      end
      chk("pause_no_tick", seen, 0);
      chk("pause_up_kept", {up, down, left, right}, 4'b1000);
      got = 0;
      for (int k = 1; k <= TD + 2; k++) begin
         step(4'b0000, 1'b1);
         if (move_tick) begin
            got = k;
            break;
         end
      end
      chk("resume_tick_cycles", got, 4);
      step(4'b0000, 1'b1);
      chk("resume_left", {up, down, left, right}, 4'b0010);

      // press landing in the tick cycle commits one period later
      do_reset("reset_tickpress");
      for (int i = 0; i < 16; i++) step(4'b0001, 1'b1);
      for (int i = 0; i < 8; i++) step(4'b1000, 1'b1);
      chk("tickpress_old_kept", {up, down, left, right}, 4'b0001);
      for (int i = 0; i < 7; i++) step(4'b1000, 1'b1);
      chk("tickpress_still_old", {up, down, left, right}, 4'b0001);
      step(4'b1000, 1'b1);
      chk("tickpress_new", {up, down, left, right}, 4'b1000);

      // random traffic against the model
      do_reset("reset_random");
      ks = '0;
      en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 11) == 0) ks[i] = ~ks[i];
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 599) == 0) do_reset("reset_random_mid");
         step(ks, en);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
